pf_req_arbiter: RTL and testbench
=================================

Name: pf_req_arbiter

Overview:
- Schedules L2 prefetch requests from two prefetch engines (in0 = SPP, in1 = BOP) onto the single L2 prefetch request port.
- Buffers each engine in a small FIFO and grants round-robin.
- Suppresses duplicate (tag,set) requests using a recent-issue filter.
- Sits between the prefetcher wrappers and the L2 request-buffer prefetch entry.

Parameters:
- TAG_W, 21, tag width
- SET_W, 9, set index width
- SRC_W, 7, source id width
- QDEPTH, 4, per-input FIFO depth (power of 2, ≥2)
- FILT_N, 8, recent-issue filter entries (power of 2)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- in0_valid / in1_valid  in  1  request valid
- in0_ready / in1_ready  out  1  FIFO can accept
- in0_tag / in1_tag  in  TAG_W  request tag
- in0_set / in1_set  in  SET_W  request set
- in0_needT / in1_needT  in  1  request needs Trunk permission
- in0_source / in1_source  in  SRC_W  source id
- out_ready  in  1  L2 accepts prefetch
- out_valid  out  1  prefetch request valid
- out_tag  out  TAG_W  issued tag
- out_set  out  SET_W  issued set
- out_needT  out  1  issued needT
- out_source  out  SRC_W  issued source id
- out_isBOP  out  1  1 if granted from in1
- flush  in  1  drop all queued/filter state
- drop_cnt  out  16  saturating count of filtered duplicates
- busy  out  1  any FIFO non-empty or out_valid

Behaviour:
- Reset (reset=0, async):
  - FIFOs empty; filter all invalid; RR pointer = in0; filter insert pointer = 0.
  - Output register invalid; drop_cnt = 0.
  - Outputs: out_valid=0, out_* fields=0, busy=0; inN_ready=1 once FIFOs are empty.
- Enqueue:
  - inN_ready = !fullN && !flush.
  - Push on inN_valid && inN_ready.
  - Push to a full FIFO is impossible (ready low). Simultaneous push and pop on a full FIFO is not allowed: ready is based on the registered full flag.
- Candidate selection (one per cycle):
  - Both heads non-empty: take the RR-pointer source.
  - One head non-empty: take that source.
  - None: idle.
- Filter hit: candidate (tag,set) equals a valid filter entry AND (candidate needT=0 OR entry needT=1).
  - Pop the candidate with no issue; drop_cnt += 1, saturating at 0xFFFF.
  - RR pointer unchanged.
- needT upgrade: (tag,set) match with candidate needT=1 and entry needT=0 is NOT a hit. Issue normally and set that entry's needT=1 in place; no new insertion.
- Issue: non-hit candidate and output stage free (!out_valid || out_ready).
  - Pop the candidate and load the output register; out_isBOP = (source==in1).
  - Insert (tag,set,needT) at the filter insert pointer, valid=1; pointer += 1, wrapping mod FILT_N. Oldest entry is overwritten.
  - RR pointer moves to the other input.
- Output stage busy (out_valid && !out_ready): non-hit candidates wait; hit candidates are still dropped.
- Output handshake:
  - Fields stay stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless reloaded the same cycle.
- Latency: enqueue in cycle N → out_valid in cycle N+2 (empty system, no hit). Full throughput: 1 issue/cycle with out_ready held 1.
- flush (synchronous, one cycle):
  - Empties both FIFOs, invalidates all filter entries, clears out_valid.
  - Takes priority over same-cycle push, pop, issue and filter insertion.
  - drop_cnt and RR pointer are kept.
- Comparisons: full-width tag and set equality. Filter lookup is combinational on the candidate head.
- busy = |(!empty0, !empty1, out_valid).

Decomposition:
- Package pf_arb_pkg:
  - pf_req_t struct (tag, set, needT, source).
  - filt_entry_t (valid, tag, set, needT).
  - Default width constants.
- Sub-module pf_req_fifo (QDEPTH sync FIFO with full/empty), instantiated twice.
- Filter and RR logic inline.

Test Plan:
- Single push in0 tag=0x1A5 set=0x03 needT=0, out_ready=1 → out_valid at +2 cycles with same fields, out_isBOP=0; drop_cnt=0.
- Both inputs hold valid with distinct addresses for 8 cycles, out_ready=1 → grants alternate in0,in1,in0,…; 8 issues; both FIFOs drain.
- Push tag=0x10 set=0x5 twice on in1 → one issue, second dropped, drop_cnt=1. Then same addr with needT=1 → issued with out_needT=1. Then same addr needT=0 → dropped, drop_cnt=2.
- Issue 9 distinct addresses, then repeat the first → the repeat is issued (entry 0 overwritten after wrap); the repeat of the 9th is dropped.
- out_ready=0 with 5 pushes on in0 → out_valid held with stable fields, in0_ready=0 after 4 buffered plus 1 in the output register. Assert flush → next cycle out_valid=0, busy=0, in0_ready=1.
- Assert reset=0 mid-stream with out_valid=1 → out_valid=0 immediately (async). After release, a duplicate of a previously issued address is issued, not dropped.

Source files
------------

// File: rtl/pf_req_arbiter_pkg.sv
// Shared types and default widths for the L2 prefetch request arbiter.
// pf_req_t is one prefetch request as it travels from an engine to the L2
// port; filt_entry_t is one slot of the recent-issue duplicate filter.
// Both use the default widths. The arbiter declares its own parameter-width
// copies internally, so it also works with non-default widths.
package pf_arb_pkg;

  localparam int DEF_TAG_W  = 21;
  localparam int DEF_SET_W  = 9;
  localparam int DEF_SRC_W  = 7;
  localparam int DEF_QDEPTH = 4;
  localparam int DEF_FILT_N = 8;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_SET_W-1:0] set;
    logic                 needT;
    logic [DEF_SRC_W-1:0] source;
  } pf_req_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_SET_W-1:0] set;
    logic                 needT;
  } filt_entry_t;

  localparam int PF_REQ_W = $bits(pf_req_t);

endpackage

// File: rtl/pf_req_arbiter_if.sv
// One prefetch request channel.
// Handshake: the master drives valid together with the payload. The payload
// must stay stable while valid is high and ready is low. A transfer happens
// on every rising clock edge where valid && ready are both high. ready may
// depend combinationally on the receiver's own state, but never on valid.
//   master : drives valid, tag, set, needT, source; receives ready
//   slave  : receives valid and payload; drives ready
interface pf_req_arbiter_if #(
  parameter int TAG_W = 21,
  parameter int SET_W = 9,
  parameter int SRC_W = 7
);
  logic             valid;
  logic             ready;
  logic [TAG_W-1:0] tag;
  logic [SET_W-1:0] set;
  logic             needT;
  logic [SRC_W-1:0] source;

  modport master (output valid, tag, set, needT, source, input ready);
  modport slave  (input valid, tag, set, needT, source, output ready);
endinterface

// File: rtl/pf_req_fifo.sv
// Synchronous FIFO with DEPTH entries and first-word fall-through read.
// rdata shows the head entry whenever empty is low.
// Ports: clock, reset (async, active-low), flush (synchronous clear that
// wins over push and pop), push/wdata, pop/rdata, full, empty.
// The pointers carry one extra wrap bit, so full and empty can be told
// apart without a separate counter.
module pf_req_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // The storage array is not reset. Only the pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/pf_req_arbiter.sv
// Merges requests from two prefetch engines (in0 = SPP, in1 = BOP) onto the
// single L2 prefetch request port.
// Each engine feeds its own FIFO. The two FIFO heads are granted round-robin.
// A recent-issue filter drops requests that repeat a (tag,set) issued earlier.
// Ports: clock, reset (async, active-low); in0/in1 request channels (slave);
// out request channel (master) plus out_isBOP; flush (synchronous clear of
// FIFOs, filter and output register); drop_cnt (saturating count of
// filtered requests); busy (work pending anywhere in the block).
module pf_req_arbiter
  import pf_arb_pkg::*;
#(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int SET_W  = DEF_SET_W,
  parameter int SRC_W  = DEF_SRC_W,
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int FILT_N = DEF_FILT_N
) (
  input  logic               clock,
  input  logic               reset,
  pf_req_arbiter_if.slave    in0,
  pf_req_arbiter_if.slave    in1,
  pf_req_arbiter_if.master   out,
  output logic               out_isBOP,
  input  logic               flush,
  output logic [15:0]        drop_cnt,
  output logic               busy
);
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    logic             needT;
    logic [SRC_W-1:0] source;
  } req_t;

  localparam int RW = $bits(req_t);
  localparam int FW = $clog2(FILT_N);

  req_t w0, w1, head0, head1, cand, out_q;
  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;
  logic sel, cand_vld, rr_ptr;
  logic hit, any_match, out_free, drop, issue;
  logic out_valid_q, out_isbop_q;
  logic [FILT_N-1:0] match_vec;

  logic [FILT_N-1:0] filt_valid;
  logic [FILT_N-1:0] filt_needT;
  logic [TAG_W-1:0]  filt_tag [FILT_N];
  logic [SET_W-1:0]  filt_set [FILT_N];
  logic [FW-1:0]     ins_ptr;

  assign in0.ready = !full0 && !flush;
  assign in1.ready = !full1 && !flush;
  assign push0 = in0.valid && in0.ready;
  assign push1 = in1.valid && in1.ready;
  assign w0 = {in0.tag, in0.set, in0.needT, in0.source};
  assign w1 = {in1.tag, in1.set, in1.needT, in1.source};

  pf_req_fifo #(.W(RW), .DEPTH(QDEPTH)) u_fifo0 (
    .clock(clock), .reset(reset), .flush(flush),
    .push(push0), .wdata(w0), .pop(pop0), .rdata(head0),
    .full(full0), .empty(empty0)
  );

  pf_req_fifo #(.W(RW), .DEPTH(QDEPTH)) u_fifo1 (
    .clock(clock), .reset(reset), .flush(flush),
    .push(push1), .wdata(w1), .pop(pop1), .rdata(head1),
    .full(full1), .empty(empty1)
  );

  // sel = 0 picks in0, sel = 1 picks in1. The round-robin pointer only
  // matters when both heads are present.
  always_comb begin
    sel = 1'b0;
    if (!empty0 && !empty1) sel = rr_ptr;
    else                    sel = empty0;
  end

  assign cand_vld = !empty0 || !empty1;
  assign cand     = sel ? head1 : head0;

  // An address is stored at most once: a match that is not a hit is a needT
  // upgrade, and an upgrade updates the existing entry instead of inserting.
  always_comb begin
    hit       = 1'b0;
    any_match = 1'b0;
    match_vec = '0;
    for (int i = 0; i < FILT_N; i++) begin
      match_vec[i] = filt_valid[i] && (filt_tag[i] == cand.tag) &&
                     (filt_set[i] == cand.set);
      if (match_vec[i]) begin
        any_match = 1'b1;
        if (!cand.needT || filt_needT[i]) hit = 1'b1;
      end
    end
  end

  assign out_free = !out_valid_q || out.ready;
  assign drop     = cand_vld && hit && !flush;
  assign issue    = cand_vld && !hit && out_free && !flush;
  assign pop0     = (drop || issue) && !sel;
  assign pop1     = (drop || issue) && sel;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= 1'b0;
      ins_ptr     <= '0;
      filt_valid  <= '0;
      filt_needT  <= '0;
      for (int i = 0; i < FILT_N; i++) begin
        filt_tag[i] <= '0;
        filt_set[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_isbop_q <= 1'b0;
      out_q       <= '0;
      drop_cnt    <= '0;
    end else if (flush) begin
      filt_valid  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (issue) begin
        out_q       <= cand;
        out_isbop_q <= sel;
        out_valid_q <= 1'b1;
        rr_ptr      <= ~sel;
        if (any_match) begin
          for (int i = 0; i < FILT_N; i++)
            if (match_vec[i]) filt_needT[i] <= 1'b1;
        end else begin
          filt_valid[ins_ptr] <= 1'b1;
          filt_tag[ins_ptr]   <= cand.tag;
          filt_set[ins_ptr]   <= cand.set;
          filt_needT[ins_ptr] <= cand.needT;
          ins_ptr             <= ins_ptr + FW'(1);
        end
      end else if (out.ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out.valid  = out_valid_q;
  assign out.tag    = out_q.tag;
  assign out.set    = out_q.set;
  assign out.needT  = out_q.needT;
  assign out.source = out_q.source;
  assign out_isBOP  = out_isbop_q;
  assign busy       = !empty0 || !empty1 || out_valid_q;
endmodule

// File: tb/tb_pf_req_arbiter.sv
// Directed bench for pf_req_arbiter. Expected issues ({isBOP, request}) are
// pushed into exp_q when stimulus is applied. A monitor compares every
// accepted output beat against the front of that queue.
module tb_pf_req_arbiter;
  import pf_arb_pkg::*;

  localparam int OW = 1 + PF_REQ_W;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        out_isBOP;
  logic [15:0] drop_cnt;
  logic        busy;

  pf_req_arbiter_if in0_if ();
  pf_req_arbiter_if in1_if ();
  pf_req_arbiter_if out_if ();

  pf_req_arbiter dut (
    .clock(clock), .reset(reset),
    .in0(in0_if.slave), .in1(in1_if.slave), .out(out_if.master),
    .out_isBOP(out_isBOP), .flush(flush), .drop_cnt(drop_cnt), .busy(busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [DEF_TAG_W-1:0] tag,
                        input logic [DEF_SET_W-1:0] set, input logic needT,
                        input logic [DEF_SRC_W-1:0] src);
    in0_if.valid = v; in0_if.tag = tag; in0_if.set = set;
    in0_if.needT = needT; in0_if.source = src;
  endtask

  task automatic drive1(input logic v, input logic [DEF_TAG_W-1:0] tag,
                        input logic [DEF_SET_W-1:0] set, input logic needT,
                        input logic [DEF_SRC_W-1:0] src);
    in1_if.valid = v; in1_if.tag = tag; in1_if.set = set;
    in1_if.needT = needT; in1_if.source = src;
  endtask

  task automatic push(input int port, input logic [DEF_TAG_W-1:0] tag,
                      input logic [DEF_SET_W-1:0] set, input logic needT,
                      input logic [DEF_SRC_W-1:0] src);
    if (port == 0) drive0(1'b1, tag, set, needT, src);
    else           drive1(1'b1, tag, set, needT, src);
    tick();
    drive0(1'b0, '0, '0, 1'b0, '0);
    drive1(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic expect_out(input logic bop, input logic [DEF_TAG_W-1:0] tag,
                            input logic [DEF_SET_W-1:0] set, input logic needT,
                            input logic [DEF_SRC_W-1:0] src);
    pf_req_t r;
    r.tag = tag; r.set = set; r.needT = needT; r.source = src;
    exp_q.push_back({bop, r});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [OW-1:0] got;
    logic [OW-1:0] exp;
    if (reset && out_if.valid && out_if.ready) begin
      got = {out_isBOP, out_if.tag, out_if.set, out_if.needT, out_if.source};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %0h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        check("issue", 64'(got), 64'(exp));
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    out_if.ready = 1'b1;
    drive0(1'b0, '0, '0, 1'b0, '0);
    drive1(1'b0, '0, '0, 1'b0, '0);
    #2;
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in0_ready", 64'(in0_if.ready), 64'd1);
    check("rst_in1_ready", 64'(in1_if.ready), 64'd1);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_out_tag", 64'(out_if.tag), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // 1: single request, two-cycle latency
    expect_out(1'b0, 21'h1A5, 9'h03, 1'b0, 7'h11);
    push(0, 21'h1A5, 9'h03, 1'b0, 7'h11);
    @(negedge clock);
    check("lat_n1_valid", 64'(out_if.valid), 64'd0);
    @(negedge clock);
    check("lat_n2_valid", 64'(out_if.valid), 64'd1);
    drain(20);
    check("t1_drop_cnt", 64'(drop_cnt), 64'd0);

    // 2: reset puts the pointer back on in0, then round-robin alternation
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_out(1'b0, 21'(32'h100 + i), 9'(i), 1'b0, 7'(i));
      expect_out(1'b1, 21'(32'h200 + i), 9'(32'h10 + i), 1'b1, 7'(32'h40 + i));
    end
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 21'(32'h100 + i), 9'(i), 1'b0, 7'(i));
      drive1(1'b1, 21'(32'h200 + i), 9'(32'h10 + i), 1'b1, 7'(32'h40 + i));
      tick();
    end
    drive0(1'b0, '0, '0, 1'b0, '0);
    drive1(1'b0, '0, '0, 1'b0, '0);
    drain(40);
    tick();
    check("t2_busy", 64'(busy), 64'd0);

    // 3: duplicate filtering and needT upgrade
    expect_out(1'b1, 21'h10, 9'h5, 1'b0, 7'h21);
    push(1, 21'h10, 9'h5, 1'b0, 7'h21);
    push(1, 21'h10, 9'h5, 1'b0, 7'h22);
    repeat (4) tick();
    check("t3_drop1", 64'(drop_cnt), 64'd1);
    expect_out(1'b1, 21'h10, 9'h5, 1'b1, 7'h23);
    push(1, 21'h10, 9'h5, 1'b1, 7'h23);
    drain(20);
    push(1, 21'h10, 9'h5, 1'b0, 7'h24);
    repeat (4) tick();
    check("t3_drop2", 64'(drop_cnt), 64'd2);

    // 4: filter wrap, the oldest of nine entries is gone
    for (int i = 0; i < 9; i++) begin
      expect_out(1'b0, 21'(32'h400 + i), 9'(32'h20 + i), 1'b0, 7'(32'h30 + i));
      push(0, 21'(32'h400 + i), 9'(32'h20 + i), 1'b0, 7'(32'h30 + i));
    end
    expect_out(1'b0, 21'h400, 9'h20, 1'b0, 7'h3F);
    push(0, 21'h400, 9'h20, 1'b0, 7'h3F);
    push(0, 21'h408, 9'h28, 1'b0, 7'h3E);
    drain(40);
    repeat (4) tick();
    check("t4_drop3", 64'(drop_cnt), 64'd3);
    check("t4_busy", 64'(busy), 64'd0);

    // 5: backpressure fills FIFO plus output register, then flush
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(0, 21'(32'h3A0 + i), 9'(32'h50 + i), 1'(i), 7'(32'h60 + i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t5_hold_valid", 64'(out_if.valid), 64'd1);
      check("t5_hold_tag", 64'(out_if.tag), 64'h3A0);
      check("t5_hold_src", 64'(out_if.source), 64'h60);
      check("t5_in0_full", 64'(in0_if.ready), 64'd0);
    end
    tick();
    flush = 1'b1;
    #1 check("t5_flush_ready", 64'(in1_if.ready), 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clock);
    check("t5_post_valid", 64'(out_if.valid), 64'd0);
    check("t5_post_busy", 64'(busy), 64'd0);
    check("t5_post_ready", 64'(in0_if.ready), 64'd1);
    check("t5_keep_drop", 64'(drop_cnt), 64'd3);

    // 6: async reset with a request parked in the output register
    out_if.ready = 1'b1;
    expect_out(1'b1, 21'h77, 9'h7, 1'b0, 7'h05);
    push(1, 21'h77, 9'h7, 1'b0, 7'h05);
    drain(20);
    out_if.ready = 1'b0;
    push(0, 21'h88, 9'h8, 1'b0, 7'h06);
    repeat (2) tick();
    check("t6_parked", 64'(out_if.valid), 64'd1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", 64'(out_if.valid), 64'd0);
    check("t6_async_busy", 64'(busy), 64'd0);
    check("t6_async_drop", 64'(drop_cnt), 64'd0);
    #2 reset = 1'b1;
    out_if.ready = 1'b1;
    tick();
    expect_out(1'b1, 21'h77, 9'h7, 1'b0, 7'h09);
    push(1, 21'h77, 9'h7, 1'b0, 7'h09);
    drain(20);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
